// File: rtl/alu_seq.sv
// Registered ALU with a start/done handshake: single-cycle logic/arith/shift ops,
// plus iterative shift-add multiply and restoring unsigned divide/modulo.
package alu_pkg;
   typedef enum logic [4:0] {
      ALU_PASSA = 5'd0,
      ALU_PASSB = 5'd1,
      ALU_AND   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_XOR   = 5'd4,
      ALU_NOT   = 5'd5,
      ALU_ADD   = 5'd6,
      ALU_ADDC  = 5'd7,
      ALU_SUB   = 5'd8,
      ALU_SUBB  = 5'd9,
      ALU_SHL   = 5'd10,
      ALU_SHR   = 5'd11,
      ALU_ASHR  = 5'd12,
      ALU_ROL   = 5'd13,
      ALU_ROR   = 5'd14,
      ALU_MUL   = 5'd15,
      ALU_DIV   = 5'd16,
      ALU_MOD   = 5'd17
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } status_t;
endpackage

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  alu_op_e          operation,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             oe,
   output tri   [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output status_t          status
);

   typedef enum logic [1:0] {IDLE, ITER, FINISH} state_e;

   state_e               state, state_nx;
   alu_op_e              op_r;
   logic [SHAMT_W-1:0]   cnt;
   logic [2*WIDTH-1:0]   acc, acc_nx;
   logic [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]     result;
   logic                 go_iter;

   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     b_eff;
   logic                 add_cin;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       sh_wide;
   logic [2*WIDTH-1:0]   rot;
   logic [WIDTH-1:0]     sc_result;
   logic                 sc_c, sc_v;

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     fin_result;
   logic                 fin_c;

   assign out  = oe ? result : 'z;
   assign busy = (state != IDLE);

   // Single-cycle datapath; subtract is a + ~b + carry so C means "no borrow".
   always_comb begin
      shamt     = b[SHAMT_W-1:0];
      b_eff     = b;
      add_cin   = 1'b0;
      sh_wide   = '0;
      rot       = '0;
      sc_result = '0;
      sc_c      = 1'b0;
      sc_v      = 1'b0;
      if (operation == ALU_SUB || operation == ALU_SUBB) b_eff = ~b;
      if (operation == ALU_SUB) add_cin = 1'b1;
      if (operation == ALU_ADDC || operation == ALU_SUBB) add_cin = carry_in;
      sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
      case (operation)
         ALU_PASSA: sc_result = a;
         ALU_PASSB: sc_result = b;
         ALU_AND:   sc_result = a & b;
         ALU_OR:    sc_result = a | b;
         ALU_XOR:   sc_result = a ^ b;
         ALU_NOT:   sc_result = ~a;
         ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBB: begin
            sc_result = sum[WIDTH-1:0];
            sc_c      = sum[WIDTH];
            sc_v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SHL: begin
            sh_wide   = {1'b0, a} << shamt;
            sc_result = sh_wide[WIDTH-1:0];
            sc_c      = sh_wide[WIDTH];
         end
         ALU_SHR: begin
            sh_wide   = {a, 1'b0} >> shamt;
            sc_result = sh_wide[WIDTH:1];
            sc_c      = sh_wide[0];
         end
         ALU_ASHR: begin
            sh_wide   = $signed({a, 1'b0}) >>> shamt;
            sc_result = sh_wide[WIDTH:1];
            sc_c      = sh_wide[0];
         end
         ALU_ROL: begin
            rot       = {a, a} << shamt;
            sc_result = rot[2*WIDTH-1:WIDTH];
            sc_c      = (shamt != '0) && sc_result[0];
         end
         ALU_ROR: begin
            rot       = {a, a} >> shamt;
            sc_result = rot[WIDTH-1:0];
            sc_c      = (shamt != '0) && sc_result[WIDTH-1];
         end
         ALU_DIV: begin
            sc_result = '1;
            sc_v      = 1'b1;
         end
         ALU_MOD: begin
            sc_result = a;
            sc_v      = 1'b1;
         end
         default: sc_result = '0;
      endcase
   end

   // acc holds {high, low}: product for MUL, {remainder, quotient} for DIV/MOD.
   always_comb begin
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      trial      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
      acc_nx     = acc;
      fin_result = acc[WIDTH-1:0];
      fin_c      = 1'b0;
      if (op_r == ALU_MUL) begin
         acc_nx = {mul_sum, acc[WIDTH-1:1]};
         fin_c  = |acc[2*WIDTH-1:WIDTH];
      end else begin
         if (!trial[WIDTH]) acc_nx = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else               acc_nx = {acc[2*WIDTH-2:0], 1'b0};
         if (op_r == ALU_MOD) fin_result = acc[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      go_iter  = (operation == ALU_MUL) ||
                 ((operation == ALU_DIV || operation == ALU_MOD) && (b != '0));
      state_nx = state;
      case (state)
         IDLE:    if (start && go_iter) state_nx = ITER;
         ITER:    if (cnt == SHAMT_W'(WIDTH-1)) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= ALU_PASSA;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         result <= '0;
         status <= 4'b0100;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_r <= operation;
               cnt  <= '0;
               opnd <= (operation == ALU_MUL) ? a : b;
               acc  <= {{WIDTH{1'b0}}, (operation == ALU_MUL) ? b : a};
               if (!go_iter) begin
                  result <= sc_result;
                  status <= {sc_result[WIDTH-1], ~|sc_result, sc_c, sc_v};
                  done   <= 1'b1;
               end
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               acc <= acc_nx;
            end
            FINISH: begin
               result <= fin_result;
               status <= {fin_result[WIDTH-1], ~|fin_result, fin_c, 1'b0};
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results and NZCV, latency, handshake and reset abort.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   alu_op_e     operation;
   logic        carry_in;
   logic [31:0] a, b;
   logic        oe;
   wire  [31:0] out_bus;
   logic        busy, done;
   status_t     status;
   logic [3:0]  nzcv;
   int          checks = 0;
   int          passes = 0;

   assign nzcv = status;

   // Weak pull-ups make a released bus read as all ones.
   for (genvar i = 0; i < 32; i++) begin : g_pu
      pullup (out_bus[i]);
   end

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
      .carry_in(carry_in), .a(a), .b(b), .oe(oe), .out(out_bus),
      .busy(busy), .done(done), .status(status)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input alu_op_e op, input logic [31:0] av, input logic [31:0] bv, input logic cin);
      @(negedge clk);
      operation = op; a = av; b = bv; carry_in = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h0; carry_in = 1'b0;
   endtask

   task automatic runSingle(input string tag, input alu_op_e op, input logic [31:0] av, input logic [31:0] bv,
                            input logic cin, input logic [31:0] exp_res, input logic [3:0] exp_st);
      applyStimulus(op, av, bv, cin);
      checkOutput({tag, "_res"}, out_bus, exp_res);
      checkOutput({tag, "_nzcv"}, {28'h0, nzcv}, {28'h0, exp_st});
      checkOutput({tag, "_done"}, {31'h0, done}, 32'h1);
      checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic runMulti(input string tag, input alu_op_e op, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_res, input logic [3:0] exp_st, input logic pulse);
      int cycles;
      applyStimulus(op, av, bv, 1'b0);
      checkOutput({tag, "_busy_hi"}, {31'h0, busy}, 32'h1);
      cycles = 0;
      while (!done && cycles < 100) begin
         if (pulse && cycles == 10) begin
            operation = ALU_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      checkOutput({tag, "_latency"}, cycles, 32'd33);
      checkOutput({tag, "_res"}, out_bus, exp_res);
      checkOutput({tag, "_nzcv"}, {28'h0, nzcv}, {28'h0, exp_st});
      checkOutput({tag, "_busy_lo"}, {31'h0, busy}, 32'h0);
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
   endtask

   initial begin
      int done_count;
      rst_n = 1'b0; oe = 1'b1; start = 1'b0; operation = ALU_PASSA;
      carry_in = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out", out_bus, 32'h0);
      checkOutput("rst_nzcv", {28'h0, nzcv}, 32'h4);
      checkOutput("rst_busy", {31'h0, busy}, 32'h0);
      checkOutput("rst_done", {31'h0, done}, 32'h0);
      rst_n = 1'b1;

      runSingle("add", ALU_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 4'b0110);
      @(negedge clk);
      checkOutput("add_done_pulse", {31'h0, done}, 32'h0);
      checkOutput("add_hold", out_bus, 32'h0);
      runSingle("sub", ALU_SUB, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 4'b0011);
      runSingle("subb", ALU_SUBB, 32'h5, 32'h3, 1'b0, 32'h1, 4'b0010);
      runSingle("addc", ALU_ADDC, 32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 4'b1001);
      runSingle("ror", ALU_ROR, 32'h1, 32'h4, 1'b0, 32'h10000000, 4'b0000);
      runSingle("ashr", ALU_ASHR, 32'h80000000, 32'd31, 1'b0, 32'hFFFFFFFF, 4'b1000);
      runSingle("rol", ALU_ROL, 32'h80000001, 32'h1, 1'b0, 32'h00000003, 4'b0010);
      runSingle("shl", ALU_SHL, 32'h80000001, 32'h1, 1'b0, 32'h00000002, 4'b0010);
      runSingle("shr0", ALU_SHR, 32'h12345678, 32'h20, 1'b0, 32'h12345678, 4'b0000);
      runSingle("unknown", alu_op_e'(5'd31), 32'h5, 32'h3, 1'b0, 32'h0, 4'b0100);

      @(negedge clk);
      operation = ALU_XOR; a = 32'hF0F0; b = 32'hFF00; start = 1'b1;
      @(negedge clk);
      checkOutput("b2b_xor", out_bus, 32'h0FF0);
      checkOutput("b2b_xor_done", {31'h0, done}, 32'h1);
      operation = ALU_AND;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_and", out_bus, 32'hF000);
      checkOutput("b2b_and_done", {31'h0, done}, 32'h1);

      runMulti("mul", ALU_MUL, 32'h00010000, 32'h00010001, 32'h00010000, 4'b0010, 1'b1);
      runMulti("div", ALU_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0);
      runMulti("mod", ALU_MOD, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0);
      runSingle("div0", ALU_DIV, 32'd100, 32'd0, 1'b0, 32'hFFFFFFFF, 4'b1001);
      runSingle("mod0", ALU_MOD, 32'd55, 32'd0, 1'b0, 32'd55, 4'b0001);

      #1 oe = 1'b0;
      #1 checkOutput("oe_off", out_bus, 32'hFFFFFFFF);
      checkOutput("oe_off_nzcv", {28'h0, nzcv}, 32'h1);
      oe = 1'b1;
      #1 checkOutput("oe_on", out_bus, 32'd55);

      applyStimulus(ALU_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("abort_busy_before", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1 checkOutput("abort_busy", {31'h0, busy}, 32'h0);
      checkOutput("abort_out", out_bus, 32'h0);
      checkOutput("abort_nzcv", {28'h0, nzcv}, 32'h4);
      checkOutput("abort_done", {31'h0, done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      done_count = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_count++;
      end
      checkOutput("abort_no_done", done_count, 32'd0);
      checkOutput("abort_hold", out_bus, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
